// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter and the clock-divider path that feeds it:
// FSM encodings and the default gate length for the 50 MHz system clock.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_GATE_CYCLES = 50_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk domain and flags its rising edges.
// rise is combinational from the last sync flop and a one-cycle delay of it.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [STAGES-1:0] sync_p0;
    logic              dly_p1;

    // Clearing the chain on reset keeps a low input from looking like an edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            dly_p1  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], d_async};
            dly_p1  <= sync_p0[STAGES-1];
        end
    end

    assign q_sync = sync_p0[STAGES-1];
    assign rise   = sync_p0[STAGES-1] & ~dly_p1;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over back-to-back windows of
// GATE_CYCLES clk periods and publishes each completed window's count with a valid pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;
    logic              rise_p0;
    logic              terminal;
    logic              lost;
    logic [CNT_W-1:0]  cnt_next;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .q_sync  (),
        .rise    (rise_p0)
    );

    assign terminal = (gate_cnt == GATE_LAST);
    assign lost     = rise_p0 && (edge_cnt == CNT_MAX);
    assign cnt_next = sat_inc(edge_cnt, rise_p0);

    // The terminal cycle's own edge is folded into the published count; the next cycle
    // already belongs to the following window, so there is no dead cycle between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (en) begin
                        state <= ST_MEASURE;
                        busy  <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (terminal) begin
                        freq       <= cnt_next;
                        overflow   <= sat | lost;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                        if (!en) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        edge_cnt <= cnt_next;
                        sat      <= sat | lost;
                    end
                end
            endcase
        end
    end

endmodule
